// File: rtl/histo_pkg.sv
// Shared types and constants for the histogram read-port arbiter.
package histo_pkg;

  localparam int GRAY_W = 8;
  localparam int HIST_W = 20;
  localparam int NREQ   = 3;

  typedef logic [1:0] port_id_t;

  localparam port_id_t PORT_VGA = 2'd0;
  localparam port_id_t PORT_LUT = 2'd1;
  localparam port_id_t PORT_DBG = 2'd2;

  // One in-flight read: valid flag plus the requester it belongs to.
  typedef struct packed {
    logic     vld;
    port_id_t id;
  } rd_tag_t;

  // Encode a one-hot grant vector into a port id (VGA when empty).
  function automatic port_id_t gnt_to_id(input logic [NREQ-1:0] gnt);
    port_id_t id;
    id = PORT_VGA;
    if (gnt[1]) id = PORT_LUT;
    if (gnt[2]) id = PORT_DBG;
    return id;
  endfunction

  // Decode a port id into a one-hot strobe vector.
  function automatic logic [NREQ-1:0] id_to_onehot(input port_id_t id);
    logic [NREQ-1:0] oh;
    case (id)
      PORT_VGA: oh = 3'b001;
      PORT_LUT: oh = 3'b010;
      PORT_DBG: oh = 3'b100;
      default:  oh = 3'b000;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/histo_rd_tagpipe.sv
// Valid+id shift register that follows reads through the fixed-latency RAM path.
module histo_rd_tagpipe
  import histo_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TAP   = 3
) (
  input  logic     iClk,
  input  logic     iRst_n,
  input  logic     iLoad,
  input  port_id_t iId,
  output logic     oTapVld,
  output port_id_t oTapId
);

  rd_tag_t stage_q [DEPTH];
  rd_tag_t stage_d [DEPTH];

  // Stage 0 captures the grant in the same edge as oGnt; later stages shift.
  always_comb begin
    stage_d[0].vld = iLoad;
    stage_d[0].id  = iId;
    for (int i = 1; i < DEPTH; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  // Tag register; reset drops every in-flight read.
  always_ff @(posedge iClk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (!iRst_n) stage_q[i] <= '0;
      else         stage_q[i] <= stage_d[i];
    end
  end

  assign oTapVld = stage_q[TAP].vld;
  assign oTapId  = stage_q[TAP].id;

endmodule

// File: rtl/histo_read_arbiter.sv
// Arbitrates the histogram gray-level read port among VGA, LUT builder and
// debug dump, and routes each returned count pair to the port that asked.
module histo_read_arbiter
  import histo_pkg::*;
#(
  parameter int READ_LAT   = 3,
  parameter int STARVE_MAX = 15
) (
  input  logic              iClk,
  input  logic              iRst_n,
  input  logic [NREQ-1:0]   iReq,
  input  logic [GRAY_W-1:0] iAddr0,
  input  logic [GRAY_W-1:0] iAddr1,
  input  logic [GRAY_W-1:0] iAddr2,
  input  logic              iHold,
  output logic [NREQ-1:0]   oGnt,
  output logic [GRAY_W-1:0] oReadGray,
  input  logic [HIST_W-1:0] iGrayHisto,
  input  logic [HIST_W-1:0] iGrayCumHisto,
  output logic [NREQ-1:0]   oRdValid,
  output logic [HIST_W-1:0] oRdHisto,
  output logic [HIST_W-1:0] oRdCum
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [GRAY_W-1:0] read_gray_q, read_gray_d;
  logic [3:0]        starve1_q, starve1_d;
  logic [3:0]        starve2_q, starve2_d;
  logic              rr_q, rr_d;           // 0: port 1 next in round-robin, 1: port 2
  logic [NREQ-1:0]   rd_valid_q, rd_valid_d;
  logic [HIST_W-1:0] rd_histo_q, rd_histo_d;
  logic [HIST_W-1:0] rd_cum_q, rd_cum_d;
  logic              st1, st2;
  logic              tap_vld;
  port_id_t          tap_id;

  // Winner: starved port 1/2 first, then port 0, then round-robin between 1 and 2.
  always_comb begin
    gnt_d = '0;
    st1   = iReq[1] && (starve1_q == STARVE_LIM);
    st2   = iReq[2] && (starve2_q == STARVE_LIM);
    if (!iHold && (|iReq)) begin
      if (st1 && st2)            gnt_d = rr_q ? 3'b100 : 3'b010;
      else if (st1)              gnt_d = 3'b010;
      else if (st2)              gnt_d = 3'b100;
      else if (iReq[0])          gnt_d = 3'b001;
      else if (iReq[1] && iReq[2]) gnt_d = rr_q ? 3'b100 : 3'b010;
      else if (iReq[1])          gnt_d = 3'b010;
      else                       gnt_d = 3'b100;
    end
  end

  // Address mux, starvation counters and round-robin pointer update.
  always_comb begin
    read_gray_d = read_gray_q;
    if (gnt_d[0])      read_gray_d = iAddr0;
    else if (gnt_d[1]) read_gray_d = iAddr1;
    else if (gnt_d[2]) read_gray_d = iAddr2;

    starve1_d = starve1_q;
    if (!iReq[1] || gnt_d[1])         starve1_d = '0;
    else if (starve1_q != STARVE_LIM) starve1_d = starve1_q + 4'd1;

    starve2_d = starve2_q;
    if (!iReq[2] || gnt_d[2])         starve2_d = '0;
    else if (starve2_q != STARVE_LIM) starve2_d = starve2_q + 4'd1;

    rr_d = rr_q;
    if (gnt_d[1])      rr_d = 1'b1;
    else if (gnt_d[2]) rr_d = 1'b0;
  end

  // Capture returning counts when the aligned tag stage holds a live read.
  always_comb begin
    rd_valid_d = '0;
    rd_histo_d = rd_histo_q;
    rd_cum_d   = rd_cum_q;
    if (tap_vld) begin
      rd_valid_d = id_to_onehot(tap_id);
      rd_histo_d = iGrayHisto;
      rd_cum_d   = iGrayCumHisto;
    end
  end

  // State and output registers.
  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      gnt_q       <= '0;
      read_gray_q <= '0;
      starve1_q   <= '0;
      starve2_q   <= '0;
      rr_q        <= 1'b0;
      rd_valid_q  <= '0;
      rd_histo_q  <= '0;
      rd_cum_q    <= '0;
    end else begin
      gnt_q       <= gnt_d;
      read_gray_q <= read_gray_d;
      starve1_q   <= starve1_d;
      starve2_q   <= starve2_d;
      rr_q        <= rr_d;
      rd_valid_q  <= rd_valid_d;
      rd_histo_q  <= rd_histo_d;
      rd_cum_q    <= rd_cum_d;
    end
  end

  // Stage READ_LAT lines up with data registered READ_LAT edges after oReadGray.
  histo_rd_tagpipe #(
    .DEPTH (READ_LAT + 1),
    .TAP   (READ_LAT)
  ) u_tagpipe (
    .iClk    (iClk),
    .iRst_n  (iRst_n),
    .iLoad   (|gnt_d),
    .iId     (gnt_to_id(gnt_d)),
    .oTapVld (tap_vld),
    .oTapId  (tap_id)
  );

  assign oGnt      = gnt_q;
  assign oReadGray = read_gray_q;
  assign oRdValid  = rd_valid_q;
  assign oRdHisto  = rd_histo_q;
  assign oRdCum    = rd_cum_q;

endmodule

// File: tb/tb_histo_read_arbiter.sv
// Scoreboard bench: a rule-level arbiter model pushes expected grants and
// returns; a monitor on the falling edge pops and compares.
module tb_histo_read_arbiter;
  import histo_pkg::*;

  localparam int READ_LAT   = 3;
  localparam int STARVE_MAX = 15;

  logic              iClk = 1'b0;
  logic              iRst_n;
  logic [2:0]        iReq;
  logic [7:0]        iAddr0, iAddr1, iAddr2;
  logic              iHold;
  logic [2:0]        oGnt, oRdValid;
  logic [7:0]        oReadGray;
  logic [19:0]       iGrayHisto, iGrayCumHisto, oRdHisto, oRdCum;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    int         cyc;
    int         port;
    logic [7:0] addr;
  } exp_t;

  exp_t gq[$];
  exp_t dq[$];

  always #5 iClk = ~iClk;

  histo_read_arbiter #(.READ_LAT(READ_LAT), .STARVE_MAX(STARVE_MAX)) dut (
    .iClk          (iClk),
    .iRst_n        (iRst_n),
    .iReq          (iReq),
    .iAddr0        (iAddr0),
    .iAddr1        (iAddr1),
    .iAddr2        (iAddr2),
    .iHold         (iHold),
    .oGnt          (oGnt),
    .oReadGray     (oReadGray),
    .iGrayHisto    (iGrayHisto),
    .iGrayCumHisto (iGrayCumHisto),
    .oRdValid      (oRdValid),
    .oRdHisto      (oRdHisto),
    .oRdCum        (oRdCum)
  );

  function automatic logic [19:0] histo_fn(input logic [7:0] a);
    return 20'(a) * 20'd6 + 20'd9;
  endfunction

  function automatic logic [19:0] cum_fn(input logic [7:0] a);
    return 20'(a) * 20'd312 + 20'd64;
  endfunction

  // Histogram block: three register stages from read address to counts.
  logic [7:0] a1, a2, a3;
  always @(posedge iClk) begin
    a1 <= oReadGray;
    a2 <= a1;
    a3 <= a2;
  end
  assign iGrayHisto    = histo_fn(a3);
  assign iGrayCumHisto = cum_fn(a3);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: applies the arbitration rules to the inputs seen at each edge.
  int m_cnt[3];
  int m_rr;
  initial begin
    int w;
    bit s1, s2;
    logic [7:0] a;
    m_cnt = '{0, 0, 0};
    m_rr  = 1;
    forever begin
      @(posedge iClk);
      cyc++;
      if (!iRst_n) begin
        m_cnt = '{0, 0, 0};
        m_rr  = 1;
        dq.delete();
        gq.push_back('{cyc, -1, 8'd0});
      end else begin
        w  = -1;
        s1 = iReq[1] && (m_cnt[1] == STARVE_MAX);
        s2 = iReq[2] && (m_cnt[2] == STARVE_MAX);
        if (!iHold && iReq != 3'b000) begin
          if (s1 && s2)                 w = m_rr;
          else if (s1)                  w = 1;
          else if (s2)                  w = 2;
          else if (iReq[0])             w = 0;
          else if (iReq[1] && iReq[2])  w = m_rr;
          else if (iReq[1])             w = 1;
          else                          w = 2;
        end
        for (int j = 1; j < 3; j++) begin
          if (!iReq[j] || w == j)          m_cnt[j] = 0;
          else if (m_cnt[j] < STARVE_MAX)  m_cnt[j]++;
        end
        if (w == 1)      m_rr = 2;
        else if (w == 2) m_rr = 1;
        a = (w == 0) ? iAddr0 : (w == 1) ? iAddr1 : (w == 2) ? iAddr2 : 8'd0;
        gq.push_back('{cyc, w, a});
        if (w >= 0) dq.push_back('{cyc + READ_LAT + 1, w, a});
      end
    end
  end

  // Monitor: compares grants every cycle and returned data when presented.
  initial begin
    exp_t e;
    forever begin
      @(negedge iClk);
      if (gq.size() > 0) begin
        e = gq.pop_front();
        check("grant", 32'(oGnt), (e.port < 0) ? 32'd0 : (32'd1 << e.port));
        if (e.port >= 0 && oGnt != 3'b000) check("read_gray", 32'(oReadGray), 32'(e.addr));
      end
      if (oRdValid != 3'b000) begin
        if (dq.size() == 0) begin
          check("rd_valid_unexpected", 32'(oRdValid), 32'd0);
        end else begin
          e = dq.pop_front();
          check("rd_valid_port", 32'(oRdValid), 32'd1 << e.port);
          check("rd_latency", 32'(cyc), 32'(e.cyc));
          check("rd_histo", 32'(oRdHisto), 32'(histo_fn(e.addr)));
          check("rd_cum", 32'(oRdCum), 32'(cum_fn(e.addr)));
        end
      end else if (dq.size() > 0 && dq[0].cyc <= cyc) begin
        e = dq.pop_front();
        check("rd_valid_missing", 32'(oRdValid), 32'd1 << e.port);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic set_addr(input int i, input logic [7:0] a);
    case (i)
      0: iAddr0 = a;
      1: iAddr1 = a;
      default: iAddr2 = a;
    endcase
  endtask

  task automatic idle(input int n);
    iReq  = 3'b000;
    iHold = 1'b0;
    repeat (n) @(negedge iClk);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_gnt"}, 32'(oGnt), 32'd0);
    check({tag, "_rdvalid"}, 32'(oRdValid), 32'd0);
    check({tag, "_readgray"}, 32'(oReadGray), 32'd0);
    check({tag, "_histo"}, 32'(oRdHisto), 32'd0);
    check({tag, "_cum"}, 32'(oRdCum), 32'd0);
  endtask

  initial begin
    int first2, lat, gcount, obs;
    bit got;
    iRst_n = 1'b0;
    iReq   = 3'b000;
    iHold  = 1'b0;
    iAddr0 = 8'd0;
    iAddr1 = 8'd0;
    iAddr2 = 8'd0;
    repeat (3) @(negedge iClk);
    check_zero_outputs("reset");
    iRst_n = 1'b1;

    // Round-robin right after reset: port 1 first, then alternating.
    iReq = 3'b110; iAddr1 = 8'd11; iAddr2 = 8'd22;
    for (int n = 1; n <= 8; n++) begin
      @(negedge iClk);
      if (n == 1) check("rr_first", 32'(oGnt), 32'b010);
      if (n == 2) check("rr_second", 32'(oGnt), 32'b100);
      if (n == 3) check("rr_third", 32'(oGnt), 32'b010);
    end
    idle(8);

    // Single read from port 1.
    iReq = 3'b010; iAddr1 = 8'd128;
    got = 0; lat = 0;
    for (int n = 1; n <= 12 && !got; n++) begin
      @(negedge iClk);
      if (oGnt[1]) iReq[1] = 1'b0;
      if (oRdValid[1]) begin
        got = 1; lat = n;
        check("single_histo", 32'(oRdHisto), 32'd777);
        check("single_cum", 32'(oRdCum), 32'd40000);
      end
    end
    check("single_latency", 32'(lat), 32'd5);
    idle(8);

    // Ports 0 and 2 continuous: port 2 wins on the 16th grant.
    iReq = 3'b101; iAddr0 = 8'd5; iAddr2 = 8'd200;
    first2 = -1;
    for (int n = 1; n <= 40; n++) begin
      @(negedge iClk);
      if (oGnt[2] && first2 < 0) first2 = n;
    end
    check("starve_first_port2", 32'(first2), 32'd16);
    idle(8);

    // Port 0 streams addresses 0..255 back-to-back.
    iAddr0 = 8'd0; iReq = 3'b001; gcount = 0;
    for (int n = 0; n < 300 && iReq[0]; n++) begin
      @(negedge iClk);
      if (oGnt[0]) begin
        gcount++;
        if (iAddr0 == 8'd255) iReq[0] = 1'b0;
        else iAddr0 = iAddr0 + 8'd1;
      end
    end
    check("stream_grants", 32'(gcount), 32'd256);
    idle(8);

    // Hold with reads in flight; port 1 saturates and beats port 0 on release.
    iReq = 3'b011; iAddr0 = 8'd60; iAddr1 = 8'd61; obs = 0;
    for (int n = 0; n < 10 && obs < 2; n++) begin
      @(negedge iClk);
      if (oGnt[0]) obs++;
    end
    iHold = 1'b1;
    repeat (20) @(negedge iClk);
    iHold = 1'b0;
    @(negedge iClk);
    check("hold_release_port1", 32'(oGnt), 32'b010);
    idle(8);

    // Randomised traffic obeying the requester rule.
    for (int n = 0; n < 400; n++) begin
      @(negedge iClk);
      iHold = ($urandom_range(0, 11) == 0);
      for (int i = 0; i < 3; i++) begin
        if (iReq[i] && oGnt[i]) begin
          if ($urandom_range(0, 1) == 1) iReq[i] = 1'b0;
          else set_addr(i, 8'($urandom));
        end else if (!iReq[i] && $urandom_range(0, 2) == 0) begin
          iReq[i] = 1'b1;
          set_addr(i, 8'($urandom));
        end
      end
    end
    idle(10);

    // Reset with three reads in flight: none of them may return.
    iReq = 3'b001; iAddr0 = 8'd77;
    repeat (3) @(negedge iClk);
    iReq = 3'b000; iRst_n = 1'b0;
    @(negedge iClk);
    iRst_n = 1'b1;
    check_zero_outputs("midreset");
    for (int n = 0; n < 8; n++) begin
      @(negedge iClk);
      check("midreset_no_valid", 32'(oRdValid), 32'd0);
    end
    check("midreset_histo_held", 32'(oRdHisto), 32'd0);
    check("drain_data_queue", 32'(dq.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
